// File: rtl/mem_boot_ctrl.sv
// mem_boot_ctrl: streams host words into data memory and then instruction
// memory, releases the CPU, and supervises the run until the stop opcode
// appears.
// Optional feature: define BOOT_CTRL_TIMEOUT_EN to also end the run once
// cycle_count exceeds TIMEOUT. With the macro undefined, timeout stays 0.
module mem_boot_ctrl #(
    parameter int IMEM_WORDS = 128,
    parameter int DMEM_WORDS = 128,
    parameter int TIMEOUT    = 99999
) (
    input  logic        clk,
    input  logic        arst,
    input  logic        start,
    input  logic        host_valid,
    output logic        host_ready,
    input  logic [63:0] host_data,
    output logic [63:0] addr_ext,
    output logic        wen_ext,
    output logic [31:0] wdata_ext,
    output logic [63:0] addr_ext_2,
    output logic        wen_ext_2,
    output logic [63:0] wdata_ext_2,
    input  logic [31:0] instruction,
    output logic        enable,
    output logic        done,
    output logic        timeout,
    output logic [3:0]  stop_tag,
    output logic [31:0] cycle_count
);
    typedef enum logic [2:0] {IDLE, LOAD_D, LOAD_I, SETTLE, RUN, DONE} state_t;

    localparam logic [6:0] STOP_OPC = 7'b1111110;
    localparam logic [7:0] D_LAST   = 8'(DMEM_WORDS - 1);
    localparam logic [7:0] I_LAST   = 8'(IMEM_WORDS - 1);

    state_t     state, state_nxt;
    logic [7:0] idx, idx_nxt;
    logic       load_d_acc, load_i_acc;
    logic       stop_hit, to_hit;
    logic       unused_bits;

    // host_ready is 1 in both load states, so a valid beat there is an accepted beat
    assign load_d_acc = (state == LOAD_D) && host_valid;
    assign load_i_acc = (state == LOAD_I) && host_valid;
    assign stop_hit   = (instruction[6:0] == STOP_OPC);

`ifdef BOOT_CTRL_TIMEOUT_EN
    assign to_hit      = (cycle_count > 32'(TIMEOUT));
    assign unused_bits = ^instruction[27:7];
`else
    assign to_hit      = 1'b0;
    assign unused_bits = ^{instruction[27:7], 32'(TIMEOUT)};
`endif

    // State and load index registers
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    // Next-state, load index sequencing and state-decoded outputs
    always_comb begin
        state_nxt  = state;
        idx_nxt    = idx;
        host_ready = 1'b0;
        enable     = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = LOAD_D;
            end
            LOAD_D: begin
                host_ready = 1'b1;
                if (host_valid) begin
                    if (idx == D_LAST) begin
                        state_nxt = LOAD_I;
                        idx_nxt   = '0;
                    end else begin
                        idx_nxt = idx + 8'd1;
                    end
                end
            end
            LOAD_I: begin
                host_ready = 1'b1;
                if (host_valid) begin
                    if (idx == I_LAST) begin
                        state_nxt = SETTLE;
                        idx_nxt   = '0;
                    end else begin
                        idx_nxt = idx + 8'd1;
                    end
                end
            end
            SETTLE: begin
                // Lets the final imem strobe land before the CPU is enabled
                state_nxt = RUN;
            end
            RUN: begin
                enable = 1'b1;
                if (stop_hit || to_hit) state_nxt = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (start) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // One-cycle memory write strobes; address and data read 0 when idle
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            wen_ext_2   <= 1'b0;
            addr_ext_2  <= '0;
            wdata_ext_2 <= '0;
            wen_ext     <= 1'b0;
            addr_ext    <= '0;
            wdata_ext   <= '0;
        end else begin
            wen_ext_2   <= load_d_acc;
            addr_ext_2  <= load_d_acc ? {53'd0, idx, 3'b000} : 64'd0;
            wdata_ext_2 <= load_d_acc ? host_data : 64'd0;
            wen_ext     <= load_i_acc;
            addr_ext    <= load_i_acc ? {54'd0, idx, 2'b00} : 64'd0;
            wdata_ext   <= load_i_acc ? host_data[31:0] : 32'd0;
        end
    end

    // Run cycle counter and end-of-run status capture
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            cycle_count <= '0;
            stop_tag    <= '0;
            timeout     <= 1'b0;
        end else begin
            case (state)
                SETTLE: cycle_count <= '0;
                RUN: begin
                    // Stop opcode wins over a simultaneous timeout; counter freezes on exit
                    if (stop_hit) begin
                        stop_tag <= instruction[31:28];
                        timeout  <= 1'b0;
                    end else if (to_hit) begin
                        timeout <= 1'b1;
                    end else if (cycle_count != 32'hFFFF_FFFF) begin
                        cycle_count <= cycle_count + 32'd1;
                    end
                end
                DONE: begin
                    if (start) begin
                        cycle_count <= '0;
                        stop_tag    <= '0;
                        timeout     <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/mem_boot_ctrl.md
MEM_BOOT_CTRL -- requirements
Module: mem_boot_ctrl

Interface
REQ-001 Parameter IMEM_WORDS, default 128, number of 32-bit instruction words loaded (1..256).
REQ-002 Parameter DMEM_WORDS, default 128, number of 64-bit data words loaded (1..256).
REQ-003 Parameter TIMEOUT, default 99999, maximum run cycles before abort.
REQ-004 The block SHALL have exactly one clock; reset is asynchronous and active-high.
REQ-005 clk  input  1  sole clock, rising-edge.
REQ-006 arst  input  1  asynchronous active-high reset.
REQ-007 start  input  1  begin boot sequence; sampled in IDLE and DONE.
REQ-008 host_valid  input  1  host word available.
REQ-009 host_ready  output  1  controller accepts word this cycle.
REQ-010 host_data  input  64  host word; imem uses bits [31:0].
REQ-011 addr_ext  output  64  imem write byte address.
REQ-012 wen_ext  output  1  imem write strobe.
REQ-013 wdata_ext  output  32  imem write data.
REQ-014 addr_ext_2  output  64  dmem write byte address.
REQ-015 wen_ext_2  output  1  dmem write strobe.
REQ-016 wdata_ext_2  output  64  dmem write data.
REQ-017 instruction  input  32  CPU current fetched instruction.
REQ-018 enable  output  1  CPU run enable.
REQ-019 done  output  1  run ended (stop or timeout), held until restart.
REQ-020 timeout  output  1  run ended by timeout.
REQ-021 stop_tag  output  4  instruction[31:28] captured at stop.
REQ-022 cycle_count  output  32  run cycles counted.

Function
REQ-023 States SHALL be IDLE, LOAD_D, LOAD_I, SETTLE, RUN, DONE.
REQ-024 IDLE->LOAD_D on start=1; DONE->IDLE on start=1 (restart requires second start pulse).
REQ-025 host_ready SHALL be 1 only in LOAD_D and LOAD_I; a beat is accepted when host_valid&host_ready.
REQ-026 Accepted beat index k in LOAD_D SHALL produce, next cycle, wen_ext_2=1, addr_ext_2=k<<3, wdata_ext_2=host_data, for exactly one cycle.
REQ-027 Accepted beat index k in LOAD_I SHALL produce, next cycle, wen_ext=1, addr_ext=k<<2, wdata_ext=host_data[31:0], for exactly one cycle.
REQ-028 Acceptance of beat DMEM_WORDS-1 SHALL move to LOAD_I with index cleared; beat IMEM_WORDS-1 SHALL move to SETTLE.
REQ-029 host_valid=0 SHALL stall without writes; addresses/data SHALL return to 0 when no strobe is active.
REQ-030 SETTLE SHALL last exactly one cycle, then RUN with enable=1 and cycle_count=0.
REQ-031 In RUN cycle_count SHALL increment by 1 each cycle, saturating at 2^32-1.
REQ-032 In RUN, instruction[6:0]==7'b1111110 SHALL move to DONE next edge, enable=0, done=1, stop_tag=instruction[31:28]; cycle_count frozen.
REQ-033 Stop and timeout in the same cycle: stop SHALL take priority, timeout=0.
REQ-034 wen_ext and wen_ext_2 SHALL never be asserted simultaneously; enable SHALL never be 1 while either strobe is 1.
REQ-035 start while in LOAD_D/LOAD_I/SETTLE/RUN SHALL be ignored.

Reset
REQ-036 arst=1 SHALL immediately force IDLE, all outputs 0 (stop_tag 4'h0, cycle_count 0), load index 0, regardless of state, including mid-load or mid-run.

Configuration
REQ-037 Macro BOOT_CTRL_TIMEOUT_EN defined: in RUN, cycle_count > TIMEOUT SHALL move to DONE with done=1, timeout=1, enable=0.
REQ-038 Macro undefined: timeout tied 0, no timeout comparator; RUN ends only on stop opcode.

Verification
REQ-039 Reset mid-LOAD_I at beat 5 -> all outputs 0 same cycle, next start reloads dmem from addr_ext_2=0.
REQ-040 DMEM_WORDS=2, IMEM_WORDS=3, continuous valid, data 0x11,0x22 then 0xA,0xB,0xC -> dmem writes @0x0,0x8; imem @0x0,0x4,0x8; enable rises 2 cycles after last acceptance.
REQ-041 host_valid toggled 1/0 each cycle -> one strobe per accepted beat, indices contiguous, no extra writes.
REQ-042 instruction=0x4000007E on RUN cycle 10 -> done=1, stop_tag=4'h4, enable=0, cycle_count=10 frozen.
REQ-043 BOOT_CTRL_TIMEOUT_EN, TIMEOUT=20, no stop -> done=1, timeout=1 when cycle_count reaches 21; without macro, enable stays 1 past 100 cycles.
REQ-044 start held during RUN -> no effect; start in DONE -> IDLE, done=0.
